// File: rtl/pixel_point_filter_if.sv
// Pixel stream handshake between producer, this stage and the downstream sink.
// The slave side is the filter stage. The master side is the surrounding environment.
interface pixel_point_filter_if #(
    parameter int PIX_W    = 8,
    parameter int CHANNELS = 1
);
    logic [CHANNELS*PIX_W-1:0] pix_in;
    logic                      valid_in;
    logic                      sof_in;
    logic                      output_ready;
    logic                      module_ready;
    logic [CHANNELS*PIX_W-1:0] pix_out;
    logic                      valid_out;
    logic                      sof_out;

    modport slave (
        input  pix_in, valid_in, sof_in, module_ready,
        output output_ready, pix_out, valid_out, sof_out
    );

    modport master (
        output pix_in, valid_in, sof_in, module_ready,
        input  output_ready, pix_out, valid_out, sof_out
    );
endinterface

// File: rtl/pixel_point_filter.sv
// Per-pixel point operation stage (bypass/threshold/brightness/invert) with a
// 2-entry skid buffer, frame-aligned config and a mean frame brightness monitor.
module pixel_point_filter #(
    parameter int PIX_W          = 8,
    parameter int CHANNELS       = 1,
    parameter int LOG2_FRAME_PIX = 19
) (
    input  logic               clk,
    input  logic               reset,
    pixel_point_filter_if.slave bus,
    input  logic               filter_enable,
    input  logic [1:0]         mode,
    input  logic [7:0]         BPM_estimate,
    output logic [PIX_W-1:0]   brightness,
    output logic               brightness_valid
);
    localparam int W = CHANNELS * PIX_W;
    localparam int A = PIX_W + LOG2_FRAME_PIX + 1;
    localparam logic [PIX_W-1:0] MAX    = {PIX_W{1'b1}};
    localparam logic [PIX_W-1:0] CENTER = {1'b1, {(PIX_W-1){1'b0}}};

    logic             sh_en;
    logic [1:0]       sh_mode;
    logic [7:0]       sh_bpm;
    logic             eff_en;
    logic [1:0]       eff_mode;
    logic [7:0]       eff_bpm;
    logic [PIX_W-1:0] level;
    logic [W-1:0]     proc;

    logic             out_valid, out_sof, skid_valid, skid_sof, rdy;
    logic [W-1:0]     out_pix, skid_pix;
    logic             accept, emit, out_free, skid_next;

    logic [A-1:0]     acc;
    logic [A:0]       sum;
    logic [PIX_W:0]   mean;
    logic             have_sof;

    function automatic logic [PIX_W-1:0] point_op(
        input logic [PIX_W-1:0] p,
        input logic             en,
        input logic [1:0]       m,
        input logic [PIX_W-1:0] lvl
    );
        logic signed [PIX_W+1:0] s;
        point_op = p;
        s = $signed({2'b00, p}) + $signed({2'b00, lvl}) - $signed({2'b00, CENTER});
        if (en) begin
            case (m)
                2'd1: point_op = (p >= lvl) ? MAX : '0;
                2'd2: begin
                    if (s < 0)
                        point_op = '0;
                    else if (s > $signed({2'b00, MAX}))
                        point_op = MAX;
                    else
                        point_op = s[PIX_W-1:0];
                end
                2'd3: point_op = MAX - p;
                default: point_op = p;
            endcase
        end
    endfunction

    // A sof beat uses the config presented with it, not the stale shadow.
    assign eff_en   = bus.sof_in ? filter_enable : sh_en;
    assign eff_mode = bus.sof_in ? mode          : sh_mode;
    assign eff_bpm  = bus.sof_in ? BPM_estimate  : sh_bpm;
    // bpm * 2^PIX_W / 256 covers both the up- and down-scaling cases.
    assign level    = PIX_W'({eff_bpm, {PIX_W{1'b0}}} >> 8);

    always_comb begin
        proc = '0;
        for (int c = 0; c < CHANNELS; c++)
            proc[c*PIX_W +: PIX_W] = point_op(bus.pix_in[c*PIX_W +: PIX_W],
                                              eff_en, eff_mode, level);
    end

    assign accept    = bus.valid_in & rdy;
    assign emit      = out_valid & bus.module_ready;
    assign out_free  = ~out_valid | bus.module_ready;
    assign skid_next = out_free ? 1'b0 : (skid_valid | accept);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_en      <= 1'b0;
            sh_mode    <= 2'd0;
            sh_bpm     <= 8'd0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_pix    <= '0;
            skid_valid <= 1'b0;
            skid_sof   <= 1'b0;
            skid_pix   <= '0;
            rdy        <= 1'b0;
        end else begin
            if (accept && bus.sof_in) begin
                sh_en   <= filter_enable;
                sh_mode <= mode;
                sh_bpm  <= BPM_estimate;
            end
            if (out_free) begin
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_pix   <= skid_pix;
                    out_sof   <= skid_sof;
                end else begin
                    out_valid <= accept;
                    if (accept) begin
                        out_pix <= proc;
                        out_sof <= bus.sof_in;
                    end
                end
            end else if (accept) begin
                skid_pix <= proc;
                skid_sof <= bus.sof_in;
            end
            skid_valid <= skid_next;
            rdy        <= ~skid_next;
        end
    end

    assign bus.output_ready = rdy;
    assign bus.pix_out      = out_pix;
    assign bus.valid_out    = out_valid;
    assign bus.sof_out      = out_sof;

    assign sum  = {1'b0, acc} + (A+1)'(out_pix[PIX_W-1:0]);
    assign mean = acc[A-1:LOG2_FRAME_PIX];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc              <= '0;
            have_sof         <= 1'b0;
            brightness       <= '0;
            brightness_valid <= 1'b0;
        end else begin
            brightness_valid <= 1'b0;
            if (emit) begin
                if (out_sof) begin
                    if (have_sof) begin
                        brightness       <= mean[PIX_W] ? MAX : mean[PIX_W-1:0];
                        brightness_valid <= 1'b1;
                    end
                    acc      <= A'(out_pix[PIX_W-1:0]);
                    have_sof <= 1'b1;
                end else begin
                    acc <= sum[A] ? {A{1'b1}} : sum[A-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_pixel_point_filter.sv
// Directed bench for pixel_point_filter: PIX_W=8, one channel, 4-pixel brightness mean.
module tb_pixel_point_filter;
    logic       clk = 1'b0;
    logic       reset;
    logic       filter_enable;
    logic [1:0] mode;
    logic [7:0] BPM_estimate;
    logic [7:0] brightness;
    logic       brightness_valid;
    int         checks = 0;
    int         errors = 0;

    pixel_point_filter_if #(.PIX_W(8), .CHANNELS(1)) bus ();

    pixel_point_filter #(.PIX_W(8), .CHANNELS(1), .LOG2_FRAME_PIX(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .filter_enable    (filter_enable),
        .mode             (mode),
        .BPM_estimate     (BPM_estimate),
        .brightness       (brightness),
        .brightness_valid (brightness_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic en, input logic [1:0] m, input logic [7:0] bpm);
        filter_enable = en;
        mode          = m;
        BPM_estimate  = bpm;
    endtask

    // Present one beat, clock it in, and check it on the output one cycle later.
    task automatic push(input string tag, input logic [7:0] p, input logic s, input logic [7:0] e);
        bus.pix_in   = p;
        bus.sof_in   = s;
        bus.valid_in = 1'b1;
        tick();
        check(tag, bus.pix_out, e);
        check({tag, "_valid"}, bus.valid_out, 1);
    endtask

    task automatic idle();
        bus.valid_in = 1'b0;
        bus.sof_in   = 1'b0;
    endtask

    initial begin
        int          nxt;
        int          got;
        logic        mr;
        logic        stalled_prev;
        logic [7:0]  held;

        reset            = 1'b0;
        bus.pix_in       = '0;
        bus.valid_in     = 1'b0;
        bus.sof_in       = 1'b0;
        bus.module_ready = 1'b1;
        cfg(1'b0, 2'd0, 8'd0);
        tick();
        tick();
        check("rst_valid_out", bus.valid_out, 0);
        check("rst_pix_out", bus.pix_out, 0);
        check("rst_sof_out", bus.sof_out, 0);
        check("rst_bright", brightness, 0);
        check("rst_bright_valid", brightness_valid, 0);

        reset = 1'b1;
        tick();
        check("ready_after_rst", bus.output_ready, 1);

        // Threshold at 80, back-to-back beats
        cfg(1'b1, 2'd1, 8'd80);
        push("thr_79", 8'd79, 1'b1, 8'd0);
        check("thr_79_sof", bus.sof_out, 1);
        cfg(1'b0, 2'd0, 8'd0);
        push("thr_80", 8'd80, 1'b0, 8'd255);
        check("first_sof_no_pulse", brightness_valid, 0);
        check("thr_80_sof", bus.sof_out, 0);
        push("thr_200", 8'd200, 1'b0, 8'd255);

        // Brightness offset +22 then -28
        cfg(1'b1, 2'd2, 8'd150);
        push("bri_240", 8'd240, 1'b1, 8'd255);
        push("bri_10", 8'd10, 1'b0, 8'd32);
        cfg(1'b1, 2'd2, 8'd100);
        push("bri_20", 8'd20, 1'b1, 8'd0);
        push("bri_200", 8'd200, 1'b0, 8'd172);
        idle();
        tick();
        check("gap_valid_out", bus.valid_out, 0);

        // Backpressure: module_ready low for loop cycles 2..4
        cfg(1'b0, 2'd0, 8'd0);
        nxt = 1;
        got = 1;
        stalled_prev = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 40 && got <= 6; cyc++) begin
            mr = !(cyc >= 2 && cyc <= 4);
            bus.module_ready = mr;
            bus.valid_in     = (nxt <= 6);
            bus.pix_in       = 8'(nxt);
            bus.sof_in       = (nxt == 1);
            if (cyc == 3)
                check("bp_ready_low", bus.output_ready, 0);
            if (stalled_prev)
                check("bp_hold", bus.pix_out, held);
            if (bus.valid_out && mr) begin
                check("bp_order", bus.pix_out, got);
                got++;
            end
            stalled_prev = bus.valid_out && !mr;
            held = bus.pix_out;
            if (bus.valid_in && bus.output_ready)
                nxt++;
            tick();
        end
        check("bp_all_out", got, 7);
        bus.module_ready = 1'b1;
        idle();
        tick();
        check("bp_ready_back", bus.output_ready, 1);

        // Mid-frame mode change is ignored until the next sof
        cfg(1'b1, 2'd0, 8'd0);
        push("mid_1", 8'd1, 1'b1, 8'd1);
        push("mid_2", 8'd2, 1'b0, 8'd2);
        push("mid_3", 8'd3, 1'b0, 8'd3);
        push("mid_4", 8'd4, 1'b0, 8'd4);
        cfg(1'b1, 2'd3, 8'd0);
        push("mid_5", 8'd5, 1'b0, 8'd5);
        push("mid_6", 8'd6, 1'b0, 8'd6);
        push("mid_sof_inv", 8'd10, 1'b1, 8'd245);
        push("mid_inv_next", 8'd11, 1'b0, 8'd244);

        // Mean brightness of a 4-pixel bypass frame
        cfg(1'b0, 2'd3, 8'd0);
        push("fr_10", 8'd10, 1'b1, 8'd10);
        push("fr_20", 8'd20, 1'b0, 8'd20);
        push("fr_30", 8'd30, 1'b0, 8'd30);
        push("fr_40", 8'd40, 1'b0, 8'd40);
        push("fr_sof", 8'd99, 1'b1, 8'd99);
        idle();
        tick();
        check("mean_pulse", brightness_valid, 1);
        check("mean_value", brightness, 25);
        tick();
        check("mean_pulse_once", brightness_valid, 0);
        check("mean_hold", brightness, 25);

        // Accumulator saturation and mean clamp: 99 + 8*255 exceeds 11 bits
        for (int i = 0; i < 8; i++)
            push("sat_255", 8'd255, 1'b0, 8'd255);
        push("sat_sof", 8'd7, 1'b1, 8'd7);
        idle();
        tick();
        check("sat_pulse", brightness_valid, 1);
        check("sat_value", brightness, 255);

        // Async reset discards buffered beats
        bus.module_ready = 1'b0;
        push("rst_mid_a", 8'd50, 1'b1, 8'd50);
        bus.pix_in = 8'd60;
        tick();
        idle();
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_valid", bus.valid_out, 0);
        check("rst_mid_bvalid", brightness_valid, 0);
        check("rst_mid_bright", brightness, 0);
        reset = 1'b1;
        bus.module_ready = 1'b1;
        tick();
        tick();
        check("rst_mid_empty", bus.valid_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
